// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_core -- multi-cycle MIPS32 subset core, req/ready memory ports
// Options  : define MIPS_MC_TRAP_EN to trap on illegal instructions (else NOP)
// Revision : 1.0
// ============================================================================
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 32,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [MEM_AW-1:0]  imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [MEM_AW-1:0]  dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ready,
    output logic [31:0]        pc_out,
    output logic [2:0]         state_out,
    output logic [COUNT_W-1:0] retired,
    output logic               trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_ir;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_imm;
    logic [31:0]        r_aluout;
    logic [31:0]        r_mdr;
    logic [COUNT_W-1:0] r_retired;
    logic [31:0]        r_regs [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_legal;
    logic        w_use_imm;
    alu_op_t     w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic [4:0]  w_wb_dst;
    logic [31:0] w_wb_data;
    logic        w_wb_en;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];

    always_comb begin
        w_legal   = 1'b1;
        w_use_imm = 1'b0;
        w_alu_op  = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD:   w_alu_op = ALU_ADD;
                    F_SUB:   w_alu_op = ALU_SUB;
                    F_AND:   w_alu_op = ALU_AND;
                    F_OR:    w_alu_op = ALU_OR;
                    F_SLT:   w_alu_op = ALU_SLT;
                    default: w_legal  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: w_use_imm = 1'b1;
            OP_BEQ, OP_J:          w_use_imm = 1'b0;
            default:               w_legal   = 1'b0;
        endcase
    end

    // The one shared ALU: register-register ops, addi and address generation
    assign w_alu_b = w_use_imm ? r_imm : r_b;

    always_comb begin
        w_alu_y = r_a + w_alu_b;
        case (w_alu_op)
            ALU_ADD: w_alu_y = r_a + w_alu_b;
            ALU_SUB: w_alu_y = r_a - w_alu_b;
            ALU_AND: w_alu_y = r_a & w_alu_b;
            ALU_OR:  w_alu_y = r_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(r_a) < $signed(w_alu_b)};
            default: w_alu_y = r_a + w_alu_b;
        endcase
    end

    assign w_wb_dst  = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_aluout;
    assign w_wb_en   = (r_state == S_WB) && (w_wb_dst != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[w_wb_dst] <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_regs[w_rs];
                    r_b     <= r_regs[w_rt];
                    r_imm   <= {{16{r_ir[15]}}, r_ir[15:0]};
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!w_legal) begin
`ifdef MIPS_MC_TRAP_EN
                        r_state <= S_TRAP;
`else
                        r_retired <= r_retired + COUNT_W'(1);
                        r_state   <= S_FETCH;
`endif
                    end else begin
                        case (w_op)
                            OP_BEQ: begin
                                // r_pc already points past the branch
                                if (r_a == r_b) begin
                                    r_pc <= r_pc + {r_imm[29:0], 2'b00};
                                end
                                r_retired <= r_retired + COUNT_W'(1);
                                r_state   <= S_FETCH;
                            end
                            OP_J: begin
                                r_pc      <= {r_pc[31:28], r_ir[25:0], 2'b00};
                                r_retired <= r_retired + COUNT_W'(1);
                                r_state   <= S_FETCH;
                            end
                            OP_LW, OP_SW: begin
                                r_aluout <= w_alu_y;
                                r_state  <= S_MEM;
                            end
                            default: begin
                                r_aluout <= w_alu_y;
                                r_state  <= S_WB;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == OP_LW) begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_retired <= r_retired + COUNT_W'(1);
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + COUNT_W'(1);
                    r_state   <= S_FETCH;
                end
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

`ifdef MIPS_MC_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_trap <= 1'b0;
        end else if ((r_state == S_EXEC) && !w_legal) begin
            r_trap <= 1'b1;
        end
    end

    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    // Requests come straight from state but are held off while reset is low
    assign imem_req   = rst && (r_state == S_FETCH);
    assign dmem_req   = rst && (r_state == S_MEM);
    assign dmem_we    = dmem_req && (w_op == OP_SW);
    assign imem_addr  = r_pc[MEM_AW-1:0];
    assign dmem_addr  = r_aluout[MEM_AW-1:0];
    assign dmem_wdata = r_b;
    assign pc_out     = r_pc;
    assign state_out  = r_state;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_core -- self-checking bench with ISA-level reference model
// Revision : 1.0
// ============================================================================
module tb_mips_multicycle_core;

    localparam logic [31:0] RPC     = 32'h0000_0040;
    localparam logic [31:0] NO_STOP = 32'hFFFF_FFFF;
    localparam int          HOLD    = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ready = 1'b0;
    logic [31:0] pc_out;
    logic [2:0]  state_out;
    logic [31:0] retired;
    logic        trap;

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .RESET_PC (RPC),
        .MEM_AW   (32),
        .COUNT_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc_out     (pc_out),
        .state_out  (state_out),
        .retired    (retired),
        .trap       (trap)
    );

    // Memories seen by the DUT, plus the reference model's architectural state
    logic [31:0] imem  [1024];
    logic [31:0] dmem  [1024];
    logic [31:0] m_mem [1024];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    bit          m_trapped;
    bit          exp_mem_valid;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int          pend_cpi;
    int          i_mode;
    int          d_mode;
    logic [31:0] p;
    int          n_checks = 0;
    int          n_pass   = 0;

    typedef struct packed {
        logic [5:0]  funct;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t tv [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [31:0] target);
        return {6'h02, target[27:2]};
    endfunction

    function automatic int pick(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endfunction

    task automatic put(input logic [31:0] ins);
        imem[p[11:2]] = ins;
        p = p + 32'd4;
    endtask

    // Every unused slot jumps to itself, so stray fetches park harmlessly
    task automatic init_imem();
        for (int i = 0; i < 1024; i++) imem[i] = jtype(32'(i * 4));
        p = RPC;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc          = RPC;
        m_retired     = '0;
        m_trapped     = 0;
        exp_mem_valid = 0;
        pend_cpi      = 0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    // Architectural effect of one instruction plus its zero-wait cycle cost
    task automatic model_exec();
        logic [31:0] ins, a, b, imm, ea, nxt;
        logic [4:0]  rs, rt, rd;
        bit          legal;
        ins   = imem[m_pc[11:2]];
        rs    = ins[25:21];
        rt    = ins[20:16];
        rd    = ins[15:11];
        a     = m_reg[rs];
        b     = m_reg[rt];
        imm   = {{16{ins[15]}}, ins[15:0]};
        ea    = a + imm;
        nxt   = m_pc + 32'd4;
        legal = 1;
        pend_cpi      = 4;
        exp_mem_valid = 0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   wr(rd, a + b);
                    6'h22:   wr(rd, a - b);
                    6'h24:   wr(rd, a & b);
                    6'h25:   wr(rd, a | b);
                    6'h2A:   wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    default: legal = 0;
                endcase
            end
            6'h08: wr(rt, ea);
            6'h23: begin
                exp_mem_valid = 1; exp_we = 0; exp_addr = ea;
                wr(rt, m_mem[ea[11:2]]);
                pend_cpi = 5;
            end
            6'h2B: begin
                exp_mem_valid = 1; exp_we = 1; exp_addr = ea; exp_wdata = b;
                m_mem[ea[11:2]] = b;
            end
            6'h04: begin
                pend_cpi = 3;
                if (a == b) nxt = nxt + (imm << 2);
            end
            6'h02: begin
                pend_cpi = 3;
                nxt = {nxt[31:28], ins[25:0], 2'b00};
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            pend_cpi = 3;
`ifdef MIPS_MC_TRAP_EN
            m_trapped = 1;
`endif
        end
        m_pc = nxt;
        if (!m_trapped) m_retired = m_retired + 32'd1;
    endtask

    // Memory responders and lockstep comparison; stops after max_fetch fetches or a fetch at stop_pc
    task automatic run_prog(input int max_fetch, input int budget, input logic [31:0] stop_pc);
        int          cyc = 0, fetches = 0, last_cyc = 0, waits = 0, i_left = 0, d_left = 0;
        bit          have_prev = 0, i_busy = 0, d_busy = 0, done = 0;
        logic [31:0] fpc;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req) begin
                if (!i_busy) begin i_busy = 1; i_left = pick(i_mode); end
                if (i_left > 0) begin
                    i_left--; waits++;
                end else begin
                    i_busy     = 0;
                    imem_ready = 1'b1;
                    imem_rdata = imem[imem_addr[11:2]];
                    chk("fetch_addr", imem_addr, m_pc);
                    chk("retired_at_fetch", retired, m_retired);
                    chk("dmem_access_missing", 32'(exp_mem_valid), 32'd0);
                    if (have_prev) chk("instr_cycles", 32'(cyc - last_cyc), 32'(pend_cpi + waits));
                    have_prev = 1; last_cyc = cyc; waits = 0;
                    fpc = m_pc;
                    model_exec();
                    fetches++;
                    if (fetches >= max_fetch || fpc == stop_pc) done = 1;
                end
            end else begin
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
            if (dmem_req) begin
                if (!d_busy) begin d_busy = 1; d_left = pick(d_mode); end
                if (d_left > 0) begin
                    d_left--; waits++;
                end else begin
                    d_busy     = 0;
                    dmem_ready = 1'b1;
                    chk("dmem_access_expected", 32'(exp_mem_valid), 32'd1);
                    chk("dmem_addr", dmem_addr, exp_addr);
                    chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                    if (dmem_we) begin
                        chk("dmem_wdata", dmem_wdata, exp_wdata);
                        dmem[dmem_addr[11:2]] = dmem_wdata;
                    end else begin
                        dmem_rdata = dmem[dmem_addr[11:2]];
                    end
                    exp_mem_valid = 0;
                end
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
        end
        chk("run_completed_in_budget", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_imem_req", 32'(imem_req), 32'd0);
        chk("reset_dmem_req", 32'(dmem_req), 32'd0);
        chk("reset_dmem_we", 32'(dmem_we), 32'd0);
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_pc", pc_out, RPC);
        chk("reset_trap", 32'(trap), 32'd0);
        chk("reset_wdata", dmem_wdata, 32'd0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("first_fetch_req", 32'(imem_req), 32'd1);
        chk("first_fetch_addr", imem_addr, RPC);
    endtask

    task automatic build_random(input int n);
        int r, off;
        logic [5:0] fl [5];
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
        init_imem();
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 9));
`ifdef MIPS_MC_TRAP_EN
            if (r >= 8) r = 0;
`endif
            case (r)
                0, 1: put(itype(6'h08, 5'($urandom_range(1, 7)), 5'($urandom_range(0, 7)), 16'($urandom)));
                2, 3, 4: put(rtype(fl[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
                5: put(itype(6'h2B, 5'($urandom_range(0, 7)), 5'd0, 16'($urandom_range(0, 63) * 4)));
                6: put(itype(6'h23, 5'($urandom_range(0, 7)), 5'd0, 16'($urandom_range(0, 63) * 4)));
                7: begin
                    off = int'($urandom_range(0, 3));
                    if (off > n - 1 - k) off = n - 1 - k;
                    put(itype(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'(off)));
                end
                8: put(rtype(6'h21, 5'd1, 5'd1, 5'd2));
                default: put({6'h3F, 26'($urandom)});
            endcase
        end
        put(jtype(p));
    endtask

    initial begin
        logic [31:0] halt;
        bit          req_seen;

        tv[0]  = '{6'h20, 16'h0005, 16'h0007, 32'h0000_000C};
        tv[1]  = '{6'h22, 16'h0005, 16'h0007, 32'hFFFF_FFFE};
        tv[2]  = '{6'h2A, 16'hFFFE, 16'h0005, 32'h0000_0001};
        tv[3]  = '{6'h2A, 16'h0005, 16'hFFFE, 32'h0000_0000};
        tv[4]  = '{6'h24, 16'h0F0F, 16'h00FF, 32'h0000_000F};
        tv[5]  = '{6'h25, 16'h0F00, 16'h00F0, 32'h0000_0FF0};
        tv[6]  = '{6'h22, 16'hFFFF, 16'hFFFF, 32'h0000_0000};
        tv[7]  = '{6'h20, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE};
        tv[8]  = '{6'h2A, 16'h8000, 16'h7FFF, 32'h0000_0001};
        tv[9]  = '{6'h24, 16'hFFFF, 16'h1234, 32'h0000_1234};
        tv[10] = '{6'h25, 16'h8000, 16'h0000, 32'hFFFF_8000};
        tv[11] = '{6'h22, 16'h0000, 16'h0001, 32'hFFFF_FFFF};

        for (int i = 0; i < 1024; i++) begin
            dmem[i]  = {16'(i), ~16'(i)};
            m_mem[i] = {16'(i), ~16'(i)};
        end

        // ALU vectors: load operands, operate, store result to 0x200 + 4*i
        init_imem();
        for (int i = 0; i < 12; i++) begin
            put(itype(6'h08, 5'd1, 5'd0, tv[i].a));
            put(itype(6'h08, 5'd2, 5'd0, tv[i].b));
            put(rtype(tv[i].funct, 5'd3, 5'd1, 5'd2));
            put(itype(6'h2B, 5'd3, 5'd0, 16'(32'h200 + 32'(i * 4))));
        end
        put(itype(6'h08, 5'd0, 5'd0, 16'd9));
        put(itype(6'h2B, 5'd0, 5'd0, 16'h0240));
        halt = p;
        put(jtype(p));
        i_mode = 0; d_mode = 0;
        do_reset();
        run_prog(100, 800, halt);
        for (int i = 0; i < 12; i++) chk($sformatf("alu_vec_%0d", i), dmem[128 + i], tv[i].exp);
        chk("reg0_stays_zero", dmem[144], 32'd0);

        // Store/load through a two-wait-state data memory
        init_imem();
        put(itype(6'h08, 5'd1, 5'd0, 16'd5));
        put(itype(6'h08, 5'd2, 5'd0, 16'd7));
        put(rtype(6'h20, 5'd3, 5'd1, 5'd2));
        put(itype(6'h2B, 5'd3, 5'd0, 16'd8));
        put(itype(6'h23, 5'd6, 5'd0, 16'd8));
        put(itype(6'h2B, 5'd6, 5'd0, 16'd12));
        halt = p;
        put(jtype(p));
        i_mode = 0; d_mode = 2;
        do_reset();
        run_prog(100, 200, halt);
        chk("lw_result_stored", dmem[3], 32'd12);

        // Jumps and a self-looping beq
        init_imem();
        imem[RPC[11:2]] = jtype(32'h20);
        imem[8]         = jtype(32'h400);
        imem[256]       = jtype(32'h10);
        imem[4]         = itype(6'h04, 5'd0, 5'd0, 16'hFFFF);
        i_mode = -1; d_mode = -1;
        do_reset();
        run_prog(7, 200, NO_STOP);

        // Illegal opcode
        init_imem();
        put(itype(6'h08, 5'd1, 5'd0, 16'd1));
        put(32'hFC00_0000);
        put(itype(6'h2B, 5'd1, 5'd0, 16'h0020));
        halt = p;
        put(jtype(p));
        i_mode = 0; d_mode = 0;
        do_reset();
`ifdef MIPS_MC_TRAP_EN
        run_prog(2, 50, NO_STOP);
        req_seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req || dmem_req) req_seen = 1;
        end
        chk("trap_no_requests", 32'(req_seen), 32'd0);
        chk("trap_flag", 32'(trap), 32'd1);
        chk("trap_state", 32'(state_out), 32'd5);
        chk("trap_retired", retired, 32'd1);
        chk("trap_pc", pc_out, RPC + 32'd8);
`else
        run_prog(100, 100, halt);
        chk("trap_tied_low", 32'(trap), 32'd0);
`endif

        // Reset while a load is stalled on the data port
        init_imem();
        put(itype(6'h08, 5'd1, 5'd0, 16'd3));
        put(itype(6'h23, 5'd1, 5'd0, 16'd8));
        put(jtype(p));
        i_mode = 0; d_mode = HOLD;
        do_reset();
        run_prog(2, 50, NO_STOP);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (dmem_req) break;
        end
        chk("lw_request_pending", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reqs_forced_low_in_reset", 32'({imem_req, dmem_req, dmem_we}), 32'd0);
        @(negedge clk);
        chk("abort_reqs_low", 32'({imem_req, dmem_req, dmem_we}), 32'd0);
        chk("abort_state", 32'(state_out), 32'd0);
        chk("abort_retired", retired, 32'd0);
        init_imem();
        put(itype(6'h2B, 5'd1, 5'd0, 16'h0020));
        halt = p;
        put(jtype(p));
        rst = 1'b1;
        model_reset();
        #1;
        chk("restart_fetch_addr", imem_addr, RPC);
        d_mode = 0;
        run_prog(10, 50, halt);

        // Random programs with random wait states on both ports
        for (int it = 0; it < 4; it++) begin
            build_random(40);
            halt = RPC + 32'd160;
            i_mode = -1; d_mode = -1;
            do_reset();
            run_prog(100, 2000, halt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle MIPS32 core. It replaces the single-cycle datapath with a registered FSM (fetch/decode/execute/memory/writeback) sharing one ALU. It talks to separate instruction and data memories through req/ready handshakes, so wait-stated memories are supported. It is the integration point for the next-generation processor testbenches and exposes PC, state and a retired-instruction count for checking.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `MEM_AW`, 32: byte-address width driven on both memory ports; the low `MEM_AW` bits of the computed address.
- `COUNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out `MEM_AW`: fetch byte address (PC).
- `imem_rdata` in 32: instruction word.
- `imem_ready` in 1: fetch completes on an edge where req and ready are both 1.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req`.
- `dmem_addr` out `MEM_AW`: data byte address (rs + sign-extended imm).
- `dmem_wdata` out 32: store data (rt).
- `dmem_rdata` in 32: load data.
- `dmem_ready` in 1: data access completes on an edge where req and ready are both 1.
- `pc_out` out 32: current PC.
- `state_out` out 3: FSM state encoding.
- `retired` out `COUNT_W`: instructions completed.
- `trap` out 1: illegal instruction seen (only with `MIPS_MC_TRAP_EN`).

## Operation
- Supported: R-type (opcode 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02. No overflow exceptions. No delay slot. No alignment check.
- Register file: 32×32. `$0` reads 0 and writes to it are dropped. Register file is cleared on reset.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: `imem_req`=1, `imem_addr`=PC. On ready: IR←rdata, PC←PC+4, go to DECODE.
- DECODE: A←R[rs], B←R[rt], IMM←sign-extend(IR[15:0]). Go to EXEC.
- EXEC, by instruction:
  - R-type: ALUOUT←A op B, go to WB.
  - addi: ALUOUT←A+IMM, go to WB.
  - lw/sw: ALUOUT←A+IMM, go to MEM.
  - beq: if A==B then PC←PC+(IMM<<2). Retire, go to FETCH.
  - j: PC←{PC[31:28],IR[25:0],2'b00}. Retire, go to FETCH.
  - Illegal opcode or funct: see Configuration.
- MEM: `dmem_req`=1, `dmem_addr`=ALUOUT.
  - lw: on ready MDR←rdata, go to WB.
  - sw: `dmem_we`=1; on ready retire, go to FETCH.
- WB: write ALUOUT (R-type to rd, addi to rt) or MDR (lw to rt). Retire, go to FETCH.
- Retire: `retired`+1, wrapping modulo 2^`COUNT_W`.

## Timing
- Request outputs are decoded from state. While `rst`=0 they are forced to 0.
- Handshake:
  - req and addr/we/wdata stay stable until ready is sampled 1.
  - ready may already be 1 in the first req cycle (zero wait).
  - ready while req=0 is ignored.
  - req drops the cycle after completion unless the next state requests again (FETCH after FETCH never occurs).
- Cycles per instruction with zero-wait memories: beq/j 3, R-type/addi/sw 4, lw 5. Each wait cycle on a ready adds 1.
- Reset values: PC=`RESET_PC`, state=FETCH, `retired`=0, `trap`=0, IR/A/B/ALUOUT/MDR=0, all req/we=0, `dmem_wdata`=0.
- First fetch request appears in the first cycle with `rst`=1.
- Reset mid-transaction abandons the pending access; no register or memory writeback occurs from that instruction.
- `retired` increments on the same edge as the state returns to FETCH.

## Configuration
- `MIPS_MC_TRAP_EN` defined: an illegal opcode or funct in EXEC moves to TRAP.
  - `trap`=1, PC holds the address of the offending instruction +4.
  - No retire, no further requests.
  - Only reset leaves TRAP.
- Not defined:
  - Illegal instructions execute as NOP: EXEC→FETCH with a retire.
  - `trap` is tied to 0 and state 5 is unreachable.

## Test plan
- Reset release with `RESET_PC`=0x40, zero-wait memories → `imem_addr`=0x40 with req=1 in the first cycle; `retired`=0 before that.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sub $4,$1,$2; slt $5,$4,$1 → $3=12, $4=0xFFFF_FFFE, $5=1; `retired`=5 after 20 cycles.
- sw $3,8($0) then lw $6,8($0), with `dmem_ready` delayed 2 cycles per access → store seen with addr=8, data=12; $6=12; sw takes 6 cycles, lw takes 7.
- beq $1,$1,-1 at 0x10 → next fetch at 0x10 (loop). j 0x100 at 0x20 → next fetch at 0x400. addi $0,$0,9 → $0 stays 0.
- Opcode 0x3F with `MIPS_MC_TRAP_EN` → `trap`=1, state_out=5, no requests, retired unchanged. Without the macro → executes as NOP and retired+1.
- `rst`=0 asserted while `dmem_req` is waiting on a lw → next cycle all reqs=0, target register unchanged; after release, fetch restarts at `RESET_PC`.
